ev19_led_sequencer: RTL and testbench
=====================================

# ev19_led_sequencer

Hardware pattern engine that owns the LED PIO's Avalon-MM s1 port and drives it as a master. The CPU configures mode, pattern and rate through a small Avalon-MM slave. The sequencer then issues timed single-cycle writes to the PIO data (0), set (4) and clear (5) registers, so LED blinking and rotation need no software.

## Interface
Parameters:
- LED_W, 8, LED/PIO data width (2..32)
- PRESCALE_W, 24, width of period register and prescaler

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_address  in  3  config word address
- cfg_chipselect  in  1  config select
- cfg_write_n  in  1  active-low write
- cfg_writedata  in  32  write data
- cfg_readdata  out  32  read data, combinational, zero wait states
- pio_address  out  3  PIO s1 address
- pio_chipselect  out  1  PIO select
- pio_write_n  out  1  PIO active-low write
- pio_writedata  out  32  PIO write data, upper bits zero

## Operation
- Config map (cfg write = chipselect & ~write_n):
  - 0 CTRL: [0] enable, [2:1] mode: 0 static, 1 blink, 2 rotate-left, 3 rotate-right.
  - 1 PATTERN[LED_W-1:0].
  - 2 PERIOD[PRESCALE_W-1:0].
  - 3 STEP (RO).
  - 4 STATUS (RO): [1:0] state, [2] phase, [LED_W+7:8] cur.
  - Unused addresses read 0 and ignore writes.
- Internal registers: cur (rotation value), phase (blink), prescaler.
- FSM states:
  - OFF (0): no PIO writes.
  - START (1): one write of cur to address 0; phase←1; prescaler←PERIOD; then RUN.
  - RUN (2): act on each tick.
  - STOP (3): one write of 0 to address 0; then OFF.
- OFF→START when CTRL written with enable=1; cur←PATTERN.
- RUN→START on any CTRL or PATTERN write that leaves enable=1; cur←PATTERN.
- RUN/START→STOP on CTRL write with enable=0.
- Prescaler counts down in RUN only. At 0 it emits a tick and reloads PERIOD, so the tick period is PERIOD+1 clocks.
- Tick action in RUN, by mode:
  - static: no write.
  - blink: phase=1 → write PATTERN to address 5 (clear); phase=0 → write PATTERN to address 4 (set); phase toggles. Bits outside PATTERN are untouched.
  - rotate-left/right: cur rotates by 1 within LED_W, then the new cur is written to address 0.
- STEP increments (16-bit, wraps 0xFFFF→0) on every PIO write issued.
- Reset values: state OFF, CTRL/PATTERN/PERIOD/cur/phase/STEP 0, pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0.

## Timing
- All pio_* outputs are registered. Each write is exactly one cycle of chipselect=1, write_n=0; the PIO has no waitrequest.
- Config write in cycle N → START write on pio_* in cycle N+1 → RUN from N+2; the prescaler starts its count at N+2.
- Tick in cycle N → PIO write in cycle N+1. PERIOD=0 gives one write every cycle in blink/rotate.
- A config write and a tick in the same cycle: the config write wins and the tick is discarded.
- A CTRL write with enable=1 while in OFF or STOP re-enters START. A STOP already issued still completes that cycle.
- PATTERN or PERIOD writes in OFF only update the register.
- Asynchronous reset mid-write deasserts pio_chipselect immediately. No STOP write is generated.
- Rotate with cur=0 keeps writing 0, which is legal.

## Configuration
- EV19_LED_SEQ_STEP_EN defined: STEP counter present; address 3 returns {16'b0, STEP}.
- Not defined: no counter flops; address 3 reads 0. All other behaviour is identical.

## Structure
- Package ev19_led_seq_pkg holds:
  - state enum (OFF/START/RUN/STOP) and mode encodings;
  - config address constants (CTRL, PATTERN, PERIOD, STEP, STATUS);
  - PIO address constants (DATA=0, SET=4, CLR=5).
- Sub-module ev19_led_prescaler: PRESCALE_W down-counter with load, run and reload inputs and a one-cycle tick output.

## Test plan
- Reset, then write PATTERN=0x81, PERIOD=3, CTRL=0x5 (rotate-left) → write 0x81 to address 0 one cycle later, then 0x03, 0x06, 0x0C every 4 cycles.
- Blink with PATTERN=0x0F, PERIOD=1 → writes alternate address 5 then 4 with data 0x0F every 2 cycles, starting with address 5.
- Static mode with PATTERN=0xA5 → exactly one write of 0xA5 to address 0, then none for 100 cycles.
- Force a CTRL write with enable=0 in the same cycle as a tick → the only write is 0 to address 0; tick dropped; STATUS state returns to 0.
- PERIOD=0 rotate-right, PATTERN=0x01 → back-to-back writes 0x01, 0x80, 0x40. With the macro on, STEP reads 3 after those writes; with it off, STEP reads 0.
- Assert reset_n low during a PIO write → pio_chipselect drops asynchronously; all registers read 0 afterwards.

Source files
------------

// File: rtl/ev19_led_seq_pkg.sv
// ev19_led_seq_pkg: shared types for the LED pattern sequencer.
// Holds FSM states, mode codes, config and PIO register addresses.
package ev19_led_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_t;

  localparam logic [2:0] CFG_CTRL    = 3'd0;
  localparam logic [2:0] CFG_PATTERN = 3'd1;
  localparam logic [2:0] CFG_PERIOD  = 3'd2;
  localparam logic [2:0] CFG_STEP    = 3'd3;
  localparam logic [2:0] CFG_STATUS  = 3'd4;

  localparam logic [2:0] PIO_DATA = 3'd0;
  localparam logic [2:0] PIO_SET  = 3'd4;
  localparam logic [2:0] PIO_CLR  = 3'd5;

endpackage

// File: rtl/ev19_led_prescaler.sv
// ev19_led_prescaler: W-bit down-counter giving a tick every reload_i+1
// run cycles. Ports: load_i (preset), run_i (count), reload_i, tick_o.
module ev19_led_prescaler #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] reload_i,
  input  logic         load_i,
  input  logic         run_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  assign tick_o = run_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i || tick_o) begin
      cnt_q <= reload_i;
    end else if (run_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ev19_led_sequencer.sv
// ev19_led_sequencer: Avalon-MM config slave (cfg_*) plus PIO master
// (pio_*) issuing timed LED writes. EV19_LED_SEQ_STEP_EN adds STEP count.
module ev19_led_sequencer
  import ev19_led_seq_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [2:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  state_t                state_q;
  logic [2:0]            ctrl_q;
  logic [LED_W-1:0]      pattern_q;
  logic [LED_W-1:0]      cur_q;
  logic [PRESCALE_W-1:0] period_q;
  logic                  phase_q;
  logic                  pio_cs_q;
  logic                  pio_wn_q;
  logic [2:0]            pio_addr_q;
  logic [31:0]           pio_data_q;

  logic             cfg_we, wr_ctrl, wr_pat, wr_per;
  logic             restart, halt, tick, tick_go;
  logic [LED_W-1:0] pat_new, rot_l, rot_r;
  mode_t            mode;
  logic             req_d;
  logic [2:0]       addr_d;
  logic [LED_W-1:0] data_d;
  logic             unused;

  assign unused  = ^cfg_writedata;
  assign cfg_we  = cfg_chipselect && !cfg_write_n;
  assign wr_ctrl = cfg_we && (cfg_address == CFG_CTRL);
  assign wr_pat  = cfg_we && (cfg_address == CFG_PATTERN);
  assign wr_per  = cfg_we && (cfg_address == CFG_PERIOD);
  assign mode    = mode_t'(ctrl_q[2:1]);
  assign pat_new = wr_pat ? cfg_writedata[LED_W-1:0] : pattern_q;
  assign rot_l   = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
  assign rot_r   = {cur_q[0], cur_q[LED_W-1:1]};

  // enable can only be set while START/RUN, so ctrl_q[0] implies active
  assign restart = (wr_ctrl && cfg_writedata[0]) ||
                   (wr_pat && ctrl_q[0]);
  assign halt    = wr_ctrl && !cfg_writedata[0] &&
                   (state_q == ST_START || state_q == ST_RUN);
  // any config write in the tick cycle swallows the tick
  assign tick_go = tick && !cfg_we;

  ev19_led_prescaler #(.W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .reload_i (period_q),
    .load_i   (state_q == ST_START),
    .run_i    (state_q == ST_RUN),
    .tick_o   (tick)
  );

  always_comb begin
    req_d  = 1'b0;
    addr_d = PIO_DATA;
    data_d = '0;
    if (restart) begin
      req_d  = 1'b1;
      data_d = pat_new;
    end else if (halt) begin
      req_d  = 1'b1;
    end else if (state_q == ST_RUN && tick_go) begin
      unique case (mode)
        MODE_BLINK: begin
          req_d  = 1'b1;
          addr_d = phase_q ? PIO_CLR : PIO_SET;
          data_d = pattern_q;
        end
        MODE_ROTL: begin
          req_d  = 1'b1;
          data_d = rot_l;
        end
        MODE_ROTR: begin
          req_d  = 1'b1;
          data_d = rot_r;
        end
        MODE_STATIC: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      ctrl_q     <= '0;
      pattern_q  <= '0;
      period_q   <= '0;
      cur_q      <= '0;
      phase_q    <= 1'b0;
      pio_cs_q   <= 1'b0;
      pio_wn_q   <= 1'b1;
      pio_addr_q <= '0;
      pio_data_q <= '0;
    end else begin
      pio_cs_q <= req_d;
      pio_wn_q <= !req_d;
      if (req_d) begin
        pio_addr_q <= addr_d;
        pio_data_q <= 32'(data_d);
      end
      if (wr_ctrl) ctrl_q    <= cfg_writedata[2:0];
      if (wr_pat)  pattern_q <= cfg_writedata[LED_W-1:0];
      if (wr_per)  period_q  <= cfg_writedata[PRESCALE_W-1:0];
      if (restart) begin
        state_q <= ST_START;
        cur_q   <= pat_new;
      end else if (halt) begin
        state_q <= ST_STOP;
      end else begin
        case (state_q)
          ST_OFF: ;
          ST_START: begin
            phase_q <= 1'b1;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (tick_go) begin
              if (mode == MODE_BLINK) phase_q <= !phase_q;
              if (mode == MODE_ROTL)  cur_q   <= rot_l;
              if (mode == MODE_ROTR)  cur_q   <= rot_r;
            end
          end
          ST_STOP: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = pio_wn_q;
  assign pio_address    = pio_addr_q;
  assign pio_writedata  = pio_data_q;

  logic [LED_W+7:0] status_w;
  logic [31:0]      step_rd;

  assign status_w = {cur_q, 5'b0, phase_q, state_q};

`ifdef EV19_LED_SEQ_STEP_EN
  logic [15:0] step_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= '0;
    end else if (req_d) begin
      step_q <= step_q + 16'd1;
    end
  end

  assign step_rd = {16'b0, step_q};
`else
  assign step_rd = '0;
`endif

  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      CFG_CTRL:    cfg_readdata = {29'b0, ctrl_q};
      CFG_PATTERN: cfg_readdata = 32'(pattern_q);
      CFG_PERIOD:  cfg_readdata = 32'(period_q);
      CFG_STEP:    cfg_readdata = step_rd;
      CFG_STATUS:  cfg_readdata = 32'(status_w);
      default:     cfg_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ev19_led_sequencer.sv
// tb_ev19_led_sequencer: randomized self-checking bench for the LED
// sequencer; expected PIO writes come from a timing/arithmetic model.
module tb_ev19_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  cfg_address = '0;
  logic        cfg_chipselect = 1'b0;
  logic        cfg_write_n = 1'b1;
  logic [31:0] cfg_writedata = '0;
  logic [31:0] cfg_readdata;
  logic [2:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  ev19_led_sequencer #(.LED_W(8), .PRESCALE_W(24)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wq_cyc[$];
  logic [2:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  logic        wq_wn[$];

  always @(negedge clk) begin
    if (pio_chipselect === 1'b1) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(pio_address);
      wq_data.push_back(pio_writedata);
      wq_wn.push_back(pio_write_n);
    end
  end

  int tests = 0;
  int fails = 0;
  int step_exp = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  function automatic logic [31:0] rot8(input int p, input int k,
                                       input bit left);
    int s;
    s = k % 8;
    if (s == 0) return p & 255;
    if (left) return ((p << s) | (p >> (8 - s))) & 255;
    return ((p >> s) | (p << (8 - s))) & 255;
  endfunction

  function automatic int step_ref();
`ifdef EV19_LED_SEQ_STEP_EN
    return step_exp & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  task automatic clear_q();
    wq_cyc.delete();
    wq_addr.delete();
    wq_data.delete();
    wq_wn.delete();
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d,
                        output int n);
    n = cyc;
    cfg_address    = a;
    cfg_writedata  = d;
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    @(posedge clk);
    #1;
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    cfg_address    = '0;
    cfg_writedata  = '0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step_exp = 0;
    clear_q();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 ||
        pio_address !== 3'd0 || pio_writedata !== 32'd0) begin
      fails++;
      $display("FAIL reset_pio: got cs=%b wn=%b a=%0d d=%h exp 0 1 0 0",
               pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      cfg_address = 3'(a);
      #1;
      tests++;
      if (cfg_readdata !== 32'd0) begin
        fails++;
        $display("FAIL reset_reg%0d: got %h exp 0", a, cfg_readdata);
      end
    end
    cfg_address = '0;
    step_exp = 0;
    clear_q();
  endtask

  // enable with (mode, pat, per), disable in cycle n+1+k*(per+1)+off;
  // off==0 lands the disable exactly on tick k
  task automatic test_scenario(input string nm, input int mode,
                               input int pat, input int per,
                               input int k, input int off);
    int n, d, w, dm, ne;
    int          e_cyc[$];
    logic [2:0]  e_addr[$];
    logic [31:0] e_data[$];
    @(negedge clk);
    cfg_wr(3'd1, 32'(pat), dm);
    cfg_wr(3'd2, 32'(per), dm);
    clear_q();
    cfg_wr(3'd0, 32'((mode << 1) | 1), n);
    d = n + 1 + k * (per + 1) + off;
    goto(d);
    cfg_wr(3'd0, 32'(mode << 1), dm);
    repeat (2 * per + 12) @(negedge clk);

    e_cyc.push_back(n + 1); e_addr.push_back(3'd0);
    e_data.push_back(32'(pat & 255));
    for (int j = 1; j < 1000; j++) begin
      w = n + 2 + j * (per + 1);
      if (w > d) break;
      if (mode == 1) begin
        e_cyc.push_back(w);
        e_addr.push_back((j % 2 == 1) ? 3'd5 : 3'd4);
        e_data.push_back(32'(pat & 255));
      end else if (mode >= 2) begin
        e_cyc.push_back(w);
        e_addr.push_back(3'd0);
        e_data.push_back(rot8(pat, j, mode == 2));
      end
    end
    e_cyc.push_back(d + 1); e_addr.push_back(3'd0);
    e_data.push_back(32'd0);
    step_exp += e_cyc.size();

    tests++;
    if (wq_cyc.size() != e_cyc.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d writes exp %0d", nm,
               wq_cyc.size(), e_cyc.size());
    end
    ne = (wq_cyc.size() < e_cyc.size()) ? wq_cyc.size() : e_cyc.size();
    for (int i = 0; i < ne; i++) begin
      tests++;
      if (wq_cyc[i] != e_cyc[i] || wq_addr[i] !== e_addr[i] ||
          wq_data[i] !== e_data[i] || wq_wn[i] !== 1'b0) begin
        fails++;
        $display("FAIL %s_w%0d: got t+%0d a=%0d d=%h wn=%b exp t+%0d a=%0d d=%h wn=0",
                 nm, i, wq_cyc[i] - n, wq_addr[i], wq_data[i], wq_wn[i],
                 e_cyc[i] - n, e_addr[i], e_data[i]);
      end
    end
    cfg_address = 3'd4;
    #1;
    tests++;
    if (cfg_readdata[1:0] !== 2'd0) begin
      fails++;
      $display("FAIL %s_state: got %0d exp 0", nm, cfg_readdata[1:0]);
    end
    cfg_address = 3'd3;
    #1;
    tests++;
    if (cfg_readdata !== 32'(step_ref())) begin
      fails++;
      $display("FAIL %s_step: got %0d exp %0d", nm, cfg_readdata,
               step_ref());
    end
    cfg_address = '0;
  endtask

  task automatic test_back_to_back();
    int n, dm;
    int exp_d[4];
    do_reset();
    cfg_wr(3'd1, 32'h01, dm);
    cfg_wr(3'd2, 32'd0, dm);
    clear_q();
    cfg_wr(3'd0, 32'h7, n);
    goto(n + 4);
    cfg_address = 3'd3;
    #1;
    step_exp = 3;
    tests++;
    if (cfg_readdata !== 32'(step_ref())) begin
      fails++;
      $display("FAIL b2b_step3: got %0d exp %0d", cfg_readdata,
               step_ref());
    end
    cfg_address = 3'd4;
    #1;
    tests++;
    if (cfg_readdata[15:8] !== 8'h40 || cfg_readdata[1:0] !== 2'd2) begin
      fails++;
      $display("FAIL b2b_status: got %h exp cur=40 state=2", cfg_readdata);
    end
    cfg_wr(3'd0, 32'h6, dm);
    repeat (6) @(negedge clk);
    exp_d = '{32'h01, 32'h80, 32'h40, 32'h00};
    tests++;
    if (wq_cyc.size() != 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d exp 4", wq_cyc.size());
    end
    for (int i = 0; i < 4 && i < wq_cyc.size(); i++) begin
      tests++;
      if (wq_cyc[i] != n + ((i == 0) ? 1 : i + 2) ||
          wq_addr[i] !== 3'd0 || wq_data[i] !== 32'(exp_d[i])) begin
        fails++;
        $display("FAIL b2b_w%0d: got t+%0d a=%0d d=%h exp t+%0d a=0 d=%h",
                 i, wq_cyc[i] - n, wq_addr[i], wq_data[i],
                 (i == 0) ? 1 : i + 2, exp_d[i]);
      end
    end
    step_exp = 4;
  endtask

  task automatic test_reset_mid_write();
    int n, dm;
    do_reset();
    cfg_wr(3'd1, 32'h3C, dm);
    cfg_wr(3'd2, 32'd0, dm);
    cfg_wr(3'd0, 32'h5, n);
    goto(n + 1);
    tests++;
    if (pio_chipselect !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got cs=%b exp 1", pio_chipselect);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_cs: got cs=%b wn=%b exp 0 1",
               pio_chipselect, pio_write_n);
    end
    for (int a = 0; a < 8; a++) begin
      cfg_address = 3'(a);
      #1;
      tests++;
      if (cfg_readdata !== 32'd0) begin
        fails++;
        $display("FAIL rst_mid_reg%0d: got %h exp 0", a, cfg_readdata);
      end
    end
    cfg_address = '0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_q();
    step_exp = 0;
    repeat (10) @(negedge clk);
    tests++;
    if (wq_cyc.size() != 0) begin
      fails++;
      $display("FAIL rst_mid_nostop: got %0d writes exp 0", wq_cyc.size());
    end
  endtask

  initial begin
    int md, pr;
    test_reset();
    test_scenario("rotl", 2, 'h81, 3, 4, 1);
    test_scenario("blink", 1, 'h0F, 1, 4, 1);
    test_scenario("static", 0, 'hA5, 9, 10, 0);
    test_scenario("stop_tick", 2, 'h11, 2, 2, 0);
    test_scenario("rotr", 3, 'h01, 0, 5, 0);
    test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      md = $urandom_range(0, 3);
      pr = $urandom_range(0, 4);
      test_scenario($sformatf("rnd%0d", i), md, $urandom_range(0, 255),
                    pr, $urandom_range(1, 4), $urandom_range(0, pr));
    end
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
